// File: rtl/mode_button_controller.sv
// Debounced front-panel button that sequences a 4-mode operating state.
// A short press (released before the long threshold) advances mode 0->1->2->3->0.
// A long hold forces mode 0 once per press.
// Timing comes from external single-cycle strobes supplied by the slow clock divider.
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   rst          synchronous, active-high reset; overrides every other input
//   btn_raw      asynchronous pushbutton level, 1 = pressed
//   tick         1-cycle debounce sample strobe
//   hold_tick    1-cycle slow strobe used to time a long press
//   btn_db       debounced button level
//   mode         current mode, 0..3
//   mode_onehot  combinational one-hot decode of mode
//   mode_change  1-cycle pulse on every accepted mode event
//   long_press   1-cycle pulse when the long-press threshold is reached
module mode_button_controller #(
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned LONG_TICKS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       tick,
  input  logic       hold_tick,
  output logic       btn_db,
  output logic [1:0] mode,
  output logic [3:0] mode_onehot,
  output logic       mode_change,
  output logic       long_press
);

  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  localparam logic [3:0] DbLast    = 4'(DEBOUNCE_SAMPLES - 1);
  localparam logic [7:0] LongTicks = 8'(LONG_TICKS);

  logic       sync_q, btn_s_q;
  logic       btn_db_q, btn_db_d;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic [7:0] hcnt_q, hcnt_d;
  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       mode_change_q, mode_change_d;
  logic       long_press_q, long_press_d;
  logic       long_done, long_hit;

  // Debounce: a level flip needs DEBOUNCE_SAMPLES consecutive differing samples.
  // Any agreeing sample restarts the count.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (tick) begin
      if (btn_s_q == btn_db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
        btn_db_d = ~btn_db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 4'd1;
      end
    end
  end

  // Hold timing uses the pre-update btn_db, so a same-cycle tick cannot affect it.
  // Once the press has gone long, hcnt freezes, so later hold_ticks produce no second pulse.
  assign long_done = (state_q == StLong);
  assign long_hit  = btn_db_q && !long_done && hold_tick && ((hcnt_q + 8'd1) == LongTicks);

  always_comb begin
    hcnt_d = hcnt_q;
    if (!btn_db_q) begin
      hcnt_d = '0;
    end else if (!long_done && hold_tick) begin
      hcnt_d = hcnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    long_press_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_db_q) state_d = long_hit ? StLong : StPressed;
      end
      StPressed: begin
        if (!btn_db_q) begin
          state_d       = StIdle;
          mode_d        = mode_q + 2'd1;
          mode_change_d = 1'b1;
        end else if (long_hit) begin
          state_d = StLong;
        end
      end
      StLong: begin
        if (!btn_db_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A long hit forces mode 0 and still pulses mode_change when mode is already 0.
    if (long_hit) begin
      mode_d        = 2'd0;
      mode_change_d = 1'b1;
      long_press_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 1'b0;
      btn_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      db_cnt_q      <= '0;
      hcnt_q        <= '0;
      state_q       <= StIdle;
      mode_q        <= 2'd0;
      mode_change_q <= 1'b0;
      long_press_q  <= 1'b0;
    end else begin
      sync_q        <= btn_raw;
      btn_s_q       <= sync_q;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      hcnt_q        <= hcnt_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      long_press_q  <= long_press_d;
    end
  end

  assign btn_db      = btn_db_q;
  assign mode        = mode_q;
  assign mode_onehot = 4'b0001 << mode_q;
  assign mode_change = mode_change_q;
  assign long_press  = long_press_q;

endmodule

// File: tb/tb_mode_button_controller.sv
module tb_mode_button_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       tick = 1'b0;
  logic       hold_tick = 1'b0;
  logic       btn_db;
  logic [1:0] mode;
  logic [3:0] mode_onehot;
  logic       mode_change;
  logic       long_press;

  int n_cmp  = 0;
  int n_fail = 0;
  int mc_cnt = 0;
  int lp_cnt = 0;
  int mc_base;
  int lp_base;

  mode_button_controller #(
    .DEBOUNCE_SAMPLES(4),
    .LONG_TICKS      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .tick       (tick),
    .hold_tick  (hold_tick),
    .btn_db     (btn_db),
    .mode       (mode),
    .mode_onehot(mode_onehot),
    .mode_change(mode_change),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // Count pulses mid-cycle; a pulse wider than one clock is counted twice.
  always @(negedge clk) begin
    if (mode_change === 1'b1) mc_cnt++;
    if (long_press === 1'b1) lp_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every helper leaves time at 1 ns after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic do_hold();
    hold_tick = 1'b1;
    cyc(1);
    hold_tick = 1'b0;
  endtask

  task automatic set_btn(input logic v);
    btn_raw = v;
    cyc(3);
  endtask

  task automatic short_press();
    set_btn(1'b1);
    repeat (6) do_tick();
    set_btn(1'b0);
    repeat (6) do_tick();
    cyc(2);
  endtask

  initial begin
    // 1 Reset dominates a pressed button and active strobes.
    rst = 1'b1; btn_raw = 1'b1; tick = 1'b1; hold_tick = 1'b1;
    cyc(3);
    check("rst_mode", int'(mode), 0);
    check("rst_onehot", int'(mode_onehot), 1);
    check("rst_btn_db", int'(btn_db), 0);
    check("rst_mode_change", int'(mode_change), 0);
    check("rst_long_press", int'(long_press), 0);
    rst = 1'b0; tick = 1'b0; hold_tick = 1'b0; btn_raw = 1'b0;
    cyc(3);
    check("rst_no_pulses", mc_cnt + lp_cnt, 0);

    // 2 Single short press: mode 0 -> 1.
    short_press();
    check("short_mode", int'(mode), 1);
    check("short_onehot", int'(mode_onehot), 2);
    check("short_mc_count", mc_cnt, 1);
    check("short_lp_count", lp_cnt, 0);
    check("short_btn_db", int'(btn_db), 0);

    // 3 Wrap through all modes starting from 0.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("wrap_start_mode", int'(mode), 0);
    mc_base = mc_cnt;
    short_press();
    check("wrap1_mode", int'(mode), 1);
    check("wrap1_onehot", int'(mode_onehot), 4'b0010);
    short_press();
    check("wrap2_mode", int'(mode), 2);
    check("wrap2_onehot", int'(mode_onehot), 4'b0100);
    short_press();
    check("wrap3_mode", int'(mode), 3);
    check("wrap3_onehot", int'(mode_onehot), 4'b1000);
    short_press();
    check("wrap0_mode", int'(mode), 0);
    check("wrap0_onehot", int'(mode_onehot), 4'b0001);
    check("wrap_mc_count", mc_cnt - mc_base, 4);

    // 4 Glitches: three differing samples then one agreeing sample, never flips.
    mc_base = mc_cnt;
    for (int r = 0; r < 3; r++) begin
      set_btn(1'b1);
      repeat (3) do_tick();
      check("glitch_btn_db", int'(btn_db), 0);
      set_btn(1'b0);
      do_tick();
    end
    repeat (3) do_tick();
    check("glitch_btn_db_end", int'(btn_db), 0);
    check("glitch_mode", int'(mode), 0);
    check("glitch_mc_count", mc_cnt - mc_base, 0);

    // 5 Long press from mode 2.
    short_press();
    short_press();
    check("long_pre_mode", int'(mode), 2);
    mc_base = mc_cnt;
    lp_base = lp_cnt;
    set_btn(1'b1);
    repeat (4) do_tick();
    check("long_btn_db", int'(btn_db), 1);
    repeat (4) begin
      do_hold();
      cyc(1);
    end
    check("long_4_mode", int'(mode), 2);
    check("long_4_lp_count", lp_cnt - lp_base, 0);
    do_hold();
    check("long_5_long_press", int'(long_press), 1);
    check("long_5_mode_change", int'(mode_change), 1);
    check("long_5_mode", int'(mode), 0);
    cyc(1);
    check("long_5_pulse_width", int'(long_press), 0);
    do_hold();
    cyc(1);
    check("long_6_lp_count", lp_cnt - lp_base, 1);
    check("long_6_mc_count", mc_cnt - mc_base, 1);
    set_btn(1'b0);
    repeat (6) do_tick();
    cyc(2);
    check("long_rel_btn_db", int'(btn_db), 0);
    check("long_rel_mode", int'(mode), 0);
    check("long_rel_mc_count", mc_cnt - mc_base, 1);
    check("long_rel_lp_count", lp_cnt - lp_base, 1);

    // 6 Reset in the middle of a press aborts it without an event.
    short_press();
    check("mid_pre_mode", int'(mode), 1);
    set_btn(1'b1);
    repeat (4) do_tick();
    check("mid_btn_db", int'(btn_db), 1);
    repeat (3) begin
      do_hold();
      cyc(1);
    end
    mc_base = mc_cnt;
    lp_base = lp_cnt;
    rst = 1'b1;
    btn_raw = 1'b0;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_btn_db", int'(btn_db), 0);
    repeat (6) do_tick();
    cyc(2);
    check("mid_rel_mode", int'(mode), 0);
    check("mid_rel_mc_count", mc_cnt - mc_base, 0);
    check("mid_rel_lp_count", lp_cnt - lp_base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
